// File: rtl/rv32_pkg.sv
// Shared RV32I encodings and control types for the multi-cycle sequencer.
package rv32_pkg;

  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_OP     = 7'b0110011;

  localparam logic [31:0] NOP_INSN = 32'h0000_0013;

  // One-hot encoding so a corrupted state vector lands in the default arm.
  typedef enum logic [5:0] {
    ST_FETCH  = 6'b000001,
    ST_DECODE = 6'b000010,
    ST_EXEC   = 6'b000100,
    ST_MEM    = 6'b001000,
    ST_WB     = 6'b010000,
    ST_TRAP   = 6'b100000
  } state_e;

  typedef enum logic [1:0] {
    WB_ALU = 2'd0,
    WB_MEM = 2'd1,
    WB_PC4 = 2'd2
  } wb_sel_e;

  typedef enum logic [1:0] {
    PC_PLUS4 = 2'd0,
    PC_IMM   = 2'd1,
    PC_JALR  = 2'd2
  } pc_sel_e;

  typedef enum logic [3:0] {
    CL_LOAD,
    CL_OPIMM,
    CL_STORE,
    CL_BRANCH,
    CL_JAL,
    CL_JALR,
    CL_LUI,
    CL_AUIPC,
    CL_OP,
    CL_ILLEGAL
  } op_class_e;

  function automatic op_class_e classify(input logic [6:0] opc);
    op_class_e cls;
    case (opc)
      OPC_LOAD:   cls = CL_LOAD;
      OPC_OPIMM:  cls = CL_OPIMM;
      OPC_STORE:  cls = CL_STORE;
      OPC_BRANCH: cls = CL_BRANCH;
      OPC_JAL:    cls = CL_JAL;
      OPC_JALR:   cls = CL_JALR;
      OPC_LUI:    cls = CL_LUI;
      OPC_AUIPC:  cls = CL_AUIPC;
      OPC_OP:     cls = CL_OP;
      default:    cls = CL_ILLEGAL;
    endcase
    return cls;
  endfunction

endpackage

// File: rtl/mc_ctrl_fsm_perf_cnt.sv
// Free-running cycle and retired-instruction counters, wrapping modulo 2^PERF_W.
module mc_perf_cnt
  #(parameter int PERF_W = 32)
  (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              cyc_en_i,
    input  logic              inst_en_i,
    output logic [PERF_W-1:0] cycle_cnt_o,
    output logic [PERF_W-1:0] instret_cnt_o
  );

  logic [PERF_W-1:0] cycle_q, cycle_d;
  logic [PERF_W-1:0] instret_q, instret_d;

  always_comb begin
    cycle_d   = cycle_q;
    instret_d = instret_q;
    if (cyc_en_i)  cycle_d   = cycle_q + 1'b1;
    if (inst_en_i) instret_d = instret_q + 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cycle_q   <= '0;
      instret_q <= '0;
    end else begin
      cycle_q   <= cycle_d;
      instret_q <= instret_d;
    end
  end

  assign cycle_cnt_o   = cycle_q;
  assign instret_cnt_o = instret_q;

endmodule

// File: rtl/mc_ctrl_fsm.sv
// Multi-cycle RV32I control sequencer: FETCH/DECODE/EXEC/MEM/WB with trap on illegal opcodes.
// Defining MC_CTRL_PERF_EN adds the cycle_cnt / instret_cnt performance counter outputs.
module mc_ctrl_fsm
  import rv32_pkg::*;
  #(parameter int XLEN   = 32,
    parameter int PERF_W = 32)
  (
    input  logic              clk,
    input  logic              rst_n,
    output logic              imem_req,
    input  logic              imem_ack,
    input  logic [31:0]       imem_rdata,
    output logic [31:0]       ir,
    input  logic              br_cond,
    output logic              alu_a_sel,
    output logic              alu_b_sel,
    output logic              dmem_req,
    output logic              dmem_we,
    input  logic              dmem_ack,
    output logic              rf_we,
    output logic [1:0]        wb_sel,
    output logic              pc_we,
    output logic [1:0]        pc_sel,
    output logic              retire,
`ifdef MC_CTRL_PERF_EN
    output logic [PERF_W-1:0] cycle_cnt,
    output logic [PERF_W-1:0] instret_cnt,
`endif
    output logic              illegal
  );

  // The sequencer carries no XLEN-wide state; other widths have no datapath to drive.
  if (XLEN != 32 || PERF_W < 1) begin : g_unsupported_cfg
  end

  state_e    state_q, state_d;
  logic [31:0] ir_q, ir_d;
  logic      illegal_q, illegal_d;
  op_class_e cls;
  logic      sel_a, sel_b;

  assign cls = classify(ir_q[6:0]);

  // Operand selects are a pure function of the latched instruction class.
  always_comb begin
    sel_a = 1'b0;
    sel_b = 1'b0;
    case (cls)
      CL_OPIMM, CL_LOAD, CL_STORE, CL_JALR: sel_b = 1'b1;
      CL_AUIPC, CL_JAL, CL_BRANCH: begin
        sel_a = 1'b1;
        sel_b = 1'b1;
      end
      default: ;
    endcase
  end

  always_comb begin
    state_d   = state_q;
    ir_d      = ir_q;
    illegal_d = illegal_q;
    imem_req  = 1'b0;
    alu_a_sel = 1'b0;
    alu_b_sel = 1'b0;
    dmem_req  = 1'b0;
    dmem_we   = 1'b0;
    rf_we     = 1'b0;
    wb_sel    = WB_ALU;
    pc_we     = 1'b0;
    pc_sel    = PC_PLUS4;

    case (state_q)
      ST_FETCH: begin
        // Gated by rst_n so no request leaks out while reset is held.
        imem_req = rst_n;
        if (imem_ack) begin
          ir_d    = imem_rdata;
          state_d = ST_DECODE;
        end
      end

      ST_DECODE: begin
        state_d = (cls == CL_ILLEGAL) ? ST_TRAP : ST_EXEC;
      end

      ST_EXEC: begin
        alu_a_sel = sel_a;
        alu_b_sel = sel_b;
        case (cls)
          CL_BRANCH: begin
            pc_we   = 1'b1;
            pc_sel  = br_cond ? PC_IMM : PC_PLUS4;
            state_d = ST_FETCH;
          end
          CL_LOAD, CL_STORE: state_d = ST_MEM;
          default:           state_d = ST_WB;
        endcase
      end

      ST_MEM: begin
        alu_a_sel = sel_a;
        alu_b_sel = sel_b;
        dmem_req  = 1'b1;
        dmem_we   = (cls == CL_STORE);
        if (dmem_ack) begin
          if (cls == CL_STORE) begin
            pc_we   = 1'b1;
            state_d = ST_FETCH;
          end else begin
            state_d = ST_WB;
          end
        end
      end

      ST_WB: begin
        alu_a_sel = sel_a;
        alu_b_sel = sel_b;
        rf_we     = 1'b1;
        pc_we     = 1'b1;
        case (cls)
          CL_LOAD:         wb_sel = WB_MEM;
          CL_JAL, CL_JALR: wb_sel = WB_PC4;
          default:         wb_sel = WB_ALU;
        endcase
        case (cls)
          CL_JAL:  pc_sel = PC_IMM;
          CL_JALR: pc_sel = PC_JALR;
          default: pc_sel = PC_PLUS4;
        endcase
        state_d = ST_FETCH;
      end

      ST_TRAP: ;

      default: state_d = ST_TRAP;
    endcase

    if (state_d == ST_TRAP) illegal_d = 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= ST_FETCH;
      ir_q      <= NOP_INSN;
      illegal_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      ir_q      <= ir_d;
      illegal_q <= illegal_d;
    end
  end

  assign ir      = ir_q;
  assign illegal = illegal_q;
  assign retire  = pc_we;

`ifdef MC_CTRL_PERF_EN
  mc_perf_cnt #(.PERF_W(PERF_W)) u_perf (
    .clk          (clk),
    .rst_n        (rst_n),
    .cyc_en_i     (state_q != ST_TRAP),
    .inst_en_i    (retire),
    .cycle_cnt_o  (cycle_cnt),
    .instret_cnt_o(instret_cnt)
  );
`endif

endmodule

// File: tb/tb_mc_ctrl_fsm.sv
// Scoreboard bench for mc_ctrl_fsm: directed instructions, monitor checks each retirement.
module tb_mc_ctrl_fsm;

  typedef struct {
    string      name;
    int         lat;
    logic       rf;
    logic [1:0] wb;
    logic [1:0] pc;
    int         dm;
    logic       dwe;
    logic       chkAlu;
    logic       a;
    logic       b;
  } exp_t;

  logic        clk;
  logic        rst_n;
  logic        imem_req;
  logic        imem_ack;
  logic [31:0] imem_rdata;
  logic [31:0] ir;
  logic        br_cond;
  logic        alu_a_sel;
  logic        alu_b_sel;
  logic        dmem_req;
  logic        dmem_we;
  logic        dmem_ack;
  logic        rf_we;
  logic [1:0]  wb_sel;
  logic        pc_we;
  logic [1:0]  pc_sel;
  logic        retire;
  logic        illegal;
`ifdef MC_CTRL_PERF_EN
  logic [31:0] cycle_cnt;
  logic [31:0] instret_cnt;
`endif

  mc_ctrl_fsm dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .imem_req  (imem_req),
    .imem_ack  (imem_ack),
    .imem_rdata(imem_rdata),
    .ir        (ir),
    .br_cond   (br_cond),
    .alu_a_sel (alu_a_sel),
    .alu_b_sel (alu_b_sel),
    .dmem_req  (dmem_req),
    .dmem_we   (dmem_we),
    .dmem_ack  (dmem_ack),
    .rf_we     (rf_we),
    .wb_sel    (wb_sel),
    .pc_we     (pc_we),
    .pc_sel    (pc_sel),
    .retire    (retire),
`ifdef MC_CTRL_PERF_EN
    .cycle_cnt  (cycle_cnt),
    .instret_cnt(instret_cnt),
`endif
    .illegal   (illegal)
  );

  int   compared   = 0;
  int   mismatched = 0;
  exp_t sbQ[$];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] req);
    compared++;
    if (act !== req) begin
      mismatched++;
      $display("[TB] FAIL %s: got %0h expected %0h", name, act, req);
    end
  endtask

  function automatic exp_t mkExp(input string n, input int lat, input logic rf, input logic [1:0] wb,
                                 input logic [1:0] pc, input int dm, input logic dwe,
                                 input logic chkAlu, input logic a, input logic b);
    exp_t e;
    e.name = n; e.lat = lat; e.rf = rf; e.wb = wb; e.pc = pc;
    e.dm = dm; e.dwe = dwe; e.chkAlu = chkAlu; e.a = a; e.b = b;
    return e;
  endfunction

  // Monitor: accumulates per-instruction activity and compares at every retirement.
  int   cyc = 0, dcnt = 0, rfcnt = 0;
  logic dweSeen = 1'b0, aSeen = 1'b0, bSeen = 1'b0, overlap = 1'b0;
  always @(negedge clk) begin
    if (!rst_n || (imem_req && !imem_ack)) begin
      cyc = 0; dcnt = 0; rfcnt = 0; overlap = 1'b0;
    end else begin
      cyc++;
      if (cyc == 3) begin aSeen = alu_a_sel; bSeen = alu_b_sel; end
      if (dmem_req) begin dcnt++; dweSeen = dmem_we; end
      if (dmem_req && imem_req) overlap = 1'b1;
      if (rf_we) rfcnt++;
      if (pc_we) begin
        if (sbQ.size() == 0) begin
          checkOutput("unexpected retire", 32'd1, 32'd0);
        end else begin
          exp_t e;
          e = sbQ.pop_front();
          checkOutput({e.name, " latency"}, cyc, e.lat);
          checkOutput({e.name, " rf_we count"}, rfcnt, {31'd0, e.rf});
          checkOutput({e.name, " wb_sel"}, {30'd0, wb_sel}, {30'd0, e.wb});
          checkOutput({e.name, " pc_sel"}, {30'd0, pc_sel}, {30'd0, e.pc});
          checkOutput({e.name, " retire"}, {31'd0, retire}, 32'd1);
          checkOutput({e.name, " dmem cycles"}, dcnt, e.dm);
          checkOutput({e.name, " req overlap"}, {31'd0, overlap}, 32'd0);
          if (e.dm > 0) checkOutput({e.name, " dmem_we"}, {31'd0, dweSeen}, {31'd0, e.dwe});
          if (e.chkAlu) begin
            checkOutput({e.name, " alu_a_sel"}, {31'd0, aSeen}, {31'd0, e.a});
            checkOutput({e.name, " alu_b_sel"}, {31'd0, bSeen}, {31'd0, e.b});
          end
        end
        cyc = 0; dcnt = 0; rfcnt = 0; overlap = 1'b0;
      end
    end
  end

  task automatic waitImemReq(input string name);
    for (int n = 0; n < 50 && !imem_req; n++) begin
      @(posedge clk); #1;
    end
    if (!imem_req) checkOutput({name, " imem_req timeout"}, 32'd0, 32'd1);
  endtask

  task automatic waitDmemReq(input string name);
    for (int n = 0; n < 50 && !dmem_req; n++) begin
      @(posedge clk); #1;
    end
    if (!dmem_req) checkOutput({name, " dmem_req timeout"}, 32'd0, 32'd1);
  endtask

  task automatic applyStimulus(input logic [31:0] word, input logic br, input int memWait, input exp_t e);
    waitImemReq(e.name);
    sbQ.push_back(e);
    br_cond    = br;
    imem_ack   = 1'b1;
    imem_rdata = word;
    @(posedge clk); #1;
    imem_ack = 1'b0;
    if (e.dm > 0) begin
      waitDmemReq(e.name);
      repeat (memWait) begin @(posedge clk); #1; end
      dmem_ack = 1'b1;
      @(posedge clk); #1;
      dmem_ack = 1'b0;
    end
  endtask

  task automatic checkResetValues(input string tag);
    checkOutput({tag, " imem_req"}, {31'd0, imem_req}, 32'd0);
    checkOutput({tag, " dmem_req"}, {31'd0, dmem_req}, 32'd0);
    checkOutput({tag, " ir"}, ir, 32'h0000_0013);
    checkOutput({tag, " illegal"}, {31'd0, illegal}, 32'd0);
    checkOutput({tag, " strobes"}, {28'd0, rf_we, pc_we, retire, dmem_we}, 32'd0);
    checkOutput({tag, " selects"}, {26'd0, alu_a_sel, alu_b_sel, wb_sel, pc_sel}, 32'd0);
  endtask

  task automatic drain(input string tag);
    for (int n = 0; n < 30 && sbQ.size() != 0; n++) @(posedge clk);
    #1;
    checkOutput({tag, " scoreboard drained"}, sbQ.size(), 32'd0);
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    int activity;
    rst_n = 1'b0; imem_ack = 1'b0; imem_rdata = '0; br_cond = 1'b0; dmem_ack = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    checkResetValues("reset");
    rst_n = 1'b1;
    #1;
    checkOutput("first imem_req after reset", {31'd0, imem_req}, 32'd1);

    applyStimulus(32'h00500093, 1'b0, 0, mkExp("addi",      4, 1, 2'd0, 2'd0, 0, 0, 1, 0, 1));
    applyStimulus(32'h0000A103, 1'b0, 2, mkExp("lw late",   7, 1, 2'd1, 2'd0, 3, 0, 1, 0, 1));
    applyStimulus(32'h0020A223, 1'b0, 0, mkExp("sw",        4, 0, 2'd0, 2'd0, 1, 1, 1, 0, 1));
    applyStimulus(32'h00000463, 1'b1, 0, mkExp("beq taken", 3, 0, 2'd0, 2'd1, 0, 0, 1, 1, 1));
    applyStimulus(32'h00000463, 1'b0, 0, mkExp("beq not",   3, 0, 2'd0, 2'd0, 0, 0, 1, 1, 1));
    applyStimulus(32'h000280E7, 1'b0, 0, mkExp("jalr",      4, 1, 2'd2, 2'd2, 0, 0, 1, 0, 1));
    applyStimulus(32'h008000EF, 1'b0, 0, mkExp("jal",       4, 1, 2'd2, 2'd1, 0, 0, 1, 1, 1));
    applyStimulus(32'h123450B7, 1'b0, 0, mkExp("lui",       4, 1, 2'd0, 2'd0, 0, 0, 0, 0, 0));
    applyStimulus(32'h00001097, 1'b0, 0, mkExp("auipc",     4, 1, 2'd0, 2'd0, 0, 0, 1, 1, 1));
    applyStimulus(32'h002081B3, 1'b0, 0, mkExp("add",       4, 1, 2'd0, 2'd0, 0, 0, 1, 0, 0));
    applyStimulus(32'h0000A103, 1'b0, 0, mkExp("lw fast",   5, 1, 2'd1, 2'd0, 1, 0, 1, 0, 1));
    applyStimulus(32'h0020A223, 1'b0, 3, mkExp("sw late",   7, 0, 2'd0, 2'd0, 4, 1, 1, 0, 1));
    drain("main");

    // Reset in the middle of a load's MEM phase, then a stray ack.
    waitImemReq("abort lw");
    imem_ack = 1'b1; imem_rdata = 32'h0000A103;
    @(posedge clk); #1;
    imem_ack = 1'b0;
    waitDmemReq("abort lw");
    rst_n = 1'b0;
    #1;
    checkResetValues("mid-MEM reset");
    @(posedge clk); #1;
    rst_n = 1'b1;
    dmem_ack = 1'b1;
    @(posedge clk); #1;
    dmem_ack = 1'b0;
    checkOutput("stray ack imem_req", {31'd0, imem_req}, 32'd1);
    checkOutput("stray ack dmem_req", {31'd0, dmem_req}, 32'd0);
    checkOutput("stray ack ir", ir, 32'h0000_0013);
    checkOutput("stray ack strobes", {30'd0, rf_we, pc_we}, 32'd0);
    applyStimulus(32'h00500093, 1'b0, 0, mkExp("addi after abort", 4, 1, 2'd0, 2'd0, 0, 0, 1, 0, 1));
    drain("abort");

    // Illegal opcode: trap from cycle 3 and stay silent.
    waitImemReq("illegal");
    imem_ack = 1'b1; imem_rdata = 32'hFFFF_FFFF;
    @(posedge clk); #1;
    imem_ack = 1'b0;
    checkOutput("illegal cycle 2", {31'd0, illegal}, 32'd0);
    @(posedge clk); #1;
    checkOutput("illegal cycle 3", {31'd0, illegal}, 32'd1);
    activity = 0;
    for (int n = 0; n < 20; n++) begin
      if (imem_req || dmem_req || rf_we || pc_we || retire) activity++;
      imem_ack = 1'b1;
      @(posedge clk); #1;
    end
    imem_ack = 1'b0;
    checkOutput("trap activity cycles", activity, 32'd0);
    checkOutput("trap illegal sticky", {31'd0, illegal}, 32'd1);

    rst_n = 1'b0;
    #1;
    checkResetValues("reset from trap");
    @(posedge clk); #1;
    rst_n = 1'b1;
    #1;
    applyStimulus(32'h00500093, 1'b0, 0, mkExp("addi after trap", 4, 1, 2'd0, 2'd0, 0, 0, 1, 0, 1));
    drain("final");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
